// File: rtl/tof_i2c_arbiter.sv
// tof_i2c_arbiter: lets eight ToF sensor FSMs share one I2C master.
// A round-robin scheduler picks a pending requester, freezes its transaction
// descriptor, launches the master, then watches it until it finishes or times
// out. The done/error pulse goes back only to the requester that won.

module tof_i2c_arbiter #(
    parameter int         N_REQ      = 8,
    parameter logic [6:0] SLAVE_ADDR = 7'h11,
    parameter int         BUSY_WAIT  = 16,
    parameter int         TIMEOUT    = 2000000
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [N_REQ-1:0]      req_start_i,
    input  logic [16*N_REQ-1:0]   req_register_address_i,
    input  logic [N_REQ-1:0]      req_is_read_i,
    input  logic [10*N_REQ-1:0]   req_nb_of_bytes_i,
    output logic [N_REQ-1:0]      req_done_o,
    output logic [N_REQ-1:0]      req_error_o,
    output logic [N_REQ-1:0]      grant_o,
    output logic                  m_start_o,
    output logic [6:0]            m_slave_address_o,
    output logic [15:0]           m_register_address_o,
    output logic                  m_is_read_o,
    output logic [9:0]            m_nb_of_bytes_o,
    output logic                  m_abort_o,
    input  logic                  m_ready_i,
    input  logic                  m_error_i,
    output logic                  timeout_flag_o
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = 22;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_LAUNCH,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_RESPOND
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   win_q, win_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [15:0]        addr_q, addr_d;
    logic               is_read_q, is_read_d;
    logic [9:0]         nb_q, nb_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic               abort_q, abort_d;
    logic               timeout_flag_q, timeout_flag_d;

    logic [15:0]        req_addr_arr [N_REQ];
    logic [9:0]         req_nb_arr   [N_REQ];
    logic               scan_found;
    logic [IDX_W-1:0]   scan_idx;
    logic [IDX_W:0]     cand;

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign req_addr_arr[g] = req_register_address_i[16*g +: 16];
        assign req_nb_arr[g]   = req_nb_of_bytes_i[10*g +: 10];
    end

    // Round-robin search: first pending requester starting at rr_ptr and wrapping.
    always_comb begin
        scan_found = 1'b0;
        scan_idx   = '0;
        cand       = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(N_REQ)) begin
                cand = cand - (IDX_W+1)'(N_REQ);
            end
            if (!scan_found && req_start_i[cand[IDX_W-1:0]]) begin
                scan_found = 1'b1;
                scan_idx   = cand[IDX_W-1:0];
            end
        end
    end

    // Next-state logic: sequencing of one arbitrated transaction.
    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        win_d          = win_q;
        grant_d        = grant_q;
        addr_d         = addr_q;
        is_read_d      = is_read_q;
        nb_d           = nb_q;
        cnt_d          = cnt_q;
        err_d          = err_q;
        abort_d        = 1'b0;
        timeout_flag_d = timeout_flag_q;

        case (state_q)
            S_IDLE: begin
                if ((|req_start_i) && m_ready_i) begin
                    state_d = S_ARB;
                end
            end
            S_ARB: begin
                if (scan_found) begin
                    win_d            = scan_idx;
                    grant_d          = '0;
                    grant_d[scan_idx] = 1'b1;
                    addr_d           = req_addr_arr[scan_idx];
                    is_read_d        = req_is_read_i[scan_idx];
                    nb_d             = req_nb_arr[scan_idx];
                    err_d            = 1'b0;
                    state_d          = S_LAUNCH;
                end else begin
                    grant_d = '0;
                    state_d = S_IDLE;
                end
            end
            S_LAUNCH: begin
                cnt_d   = '0;
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (!m_ready_i) begin
                    cnt_d   = '0;
                    state_d = S_WAIT_DONE;
                end else if (cnt_q >= CNT_W'(BUSY_WAIT-1)) begin
                    err_d   = 1'b1;
                    state_d = S_RESPOND;
                end else begin
                    cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
                end
            end
            S_WAIT_DONE: begin
                if (m_ready_i) begin
                    err_d   = m_error_i;
                    state_d = S_RESPOND;
                end else if (cnt_q >= CNT_W'(TIMEOUT-1)) begin
                    abort_d        = 1'b1;
                    timeout_flag_d = 1'b1;
                    err_d          = 1'b1;
                    state_d        = S_RESPOND;
                end else begin
                    cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
                end
            end
            S_RESPOND: begin
                rr_ptr_d = (win_q == IDX_W'(N_REQ-1)) ? '0 : win_q + IDX_W'(1);
                grant_d  = '0;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State and descriptor registers, cleared asynchronously.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= S_IDLE;
            rr_ptr_q       <= '0;
            win_q          <= '0;
            grant_q        <= '0;
            addr_q         <= '0;
            is_read_q      <= 1'b0;
            nb_q           <= '0;
            cnt_q          <= '0;
            err_q          <= 1'b0;
            abort_q        <= 1'b0;
            timeout_flag_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            win_q          <= win_d;
            grant_q        <= grant_d;
            addr_q         <= addr_d;
            is_read_q      <= is_read_d;
            nb_q           <= nb_d;
            cnt_q          <= cnt_d;
            err_q          <= err_d;
            abort_q        <= abort_d;
            timeout_flag_q <= timeout_flag_d;
        end
    end

    assign m_start_o            = (state_q == S_LAUNCH);
    assign req_done_o           = (state_q == S_RESPOND) ? grant_q : '0;
    assign req_error_o          = ((state_q == S_RESPOND) && err_q) ? grant_q : '0;
    assign grant_o              = grant_q;
    assign m_slave_address_o    = SLAVE_ADDR;
    assign m_register_address_o = addr_q;
    assign m_is_read_o          = is_read_q;
    assign m_nb_of_bytes_o      = nb_q;
    assign m_abort_o            = abort_q;
    assign timeout_flag_o       = timeout_flag_q;

endmodule

// File: doc/tof_i2c_arbiter.md
Name: tof_i2c_arbiter

Overview:
Shares one I2C master entity between eight ToF sensor FSMs, so the eight sensors no longer need eight I2C engines. A round-robin scheduler picks one pending request, latches its transaction descriptor and launches the shared master. It watches the master until completion or timeout, then returns done/error to the winning requester only. It sits between the per-sensor ToF FSMs and a single I2C master with its IOBUF pair.

Parameters:
N_REQ, 8, number of requesters (ToF FSMs).
SLAVE_ADDR, 7'h11, 7-bit I2C slave address driven to the master.
BUSY_WAIT, 16, max cycles allowed from m_start until m_ready falls.
TIMEOUT, 2000000, max cycles allowed in WAIT_DONE before the transaction is aborted.

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous, active-low reset.
req_start  in  N_REQ  level request per requester; held high until its done pulse.
req_register_address  in  16*N_REQ  flattened; slice i = bits [16i+15:16i].
req_is_read  in  N_REQ  1 = read transaction.
req_nb_of_bytes  in  10*N_REQ  flattened byte count per requester.
req_done  out  N_REQ  one-cycle completion pulse to the served requester.
req_error  out  N_REQ  valid with req_done; 1 = master error or timeout.
grant  out  N_REQ  one-hot; index of the requester currently owning the master; 0 when idle.
m_start  out  1  one-cycle launch pulse to the I2C master.
m_slave_address  out  7  constant SLAVE_ADDR.
m_register_address  out  16  latched descriptor.
m_is_read  out  1  latched descriptor.
m_nb_of_bytes  out  10  latched descriptor.
m_abort  out  1  one-cycle pulse on timeout; resets the master's FSM.
m_ready  in  1  master idle flag.
m_error  in  1  master error, sampled when m_ready returns high.
timeout_flag  out  1  sticky; set on any timeout, cleared only by reset.

Behaviour:
- Reset is asynchronous and active-low (reset=0). While in reset:
  - state=IDLE, rr_ptr=0.
  - All outputs are 0, except m_slave_address, which is always SLAVE_ADDR.
  - Latched descriptor registers are 0.
- State IDLE:
  - If req_start≠0 and m_ready=1, go to ARB next cycle.
  - If m_ready=0 (master not yet idle after reset or abort), stay in IDLE.
- State ARB (1 cycle):
  - Winner = first set bit of req_start, scanning rr_ptr, rr_ptr+1, … modulo N_REQ.
  - Latch the winner's descriptor into m_* registers and set grant one-hot.
  - Go to LAUNCH.
  - If req_start dropped to 0 in this cycle, return to IDLE with no grant.
- State LAUNCH (1 cycle): m_start=1; reset the cycle counter; go to WAIT_BUSY.
- State WAIT_BUSY:
  - On m_ready=0, go to WAIT_DONE and reset the counter.
  - If the counter reaches BUSY_WAIT without m_ready falling, treat it as an immediate completion with error=1. No abort is issued here.
- State WAIT_DONE:
  - On m_ready=1, capture m_error and go to RESPOND.
  - If the counter reaches TIMEOUT-1, pulse m_abort for 1 cycle, set timeout_flag, force error=1 and go to RESPOND.
- State RESPOND (1 cycle):
  - req_done[w]=1 and req_error[w]=captured error, where w is the winner.
  - rr_ptr ← (w+1) mod N_REQ.
  - grant cleared; go to IDLE.
- Latency: request in IDLE to m_start is 2 cycles (ARB, LAUNCH).
- Descriptor handling:
  - The descriptor is frozen from ARB to RESPOND.
  - Requester input changes during the transaction are ignored.
- req_start dropped by the winner mid-transaction: the transaction still completes and req_done is still pulsed. The requester may ignore it.
- Fairness: a requester held high is served within N_REQ transactions.
- Simultaneous events:
  - If m_ready rises in the same cycle the timeout expires, the m_ready completion wins: no abort, error=m_error.
- Counters: 22-bit saturating; widths must cover TIMEOUT.
- Reset mid-transaction: all outputs drop immediately (asynchronous); no done pulse is issued.

Test Plan:
- Single request: req_start=8'h04, addr slice2=16'h0010, read, 2 bytes → grant=8'h04; m_start 2 cycles later with m_register_address=16'h0010, m_nb_of_bytes=2. Bench master holds ready low 50 cycles → req_done[2] one pulse, req_error[2]=0, rr_ptr=3.
- Round-robin: req_start=8'hFF held, each transaction completes → grant order 0,1,…,7,0; no requester served twice before all served.
- Error propagation: master returns m_error=1 on ready rise for requester 5 → req_done[5]=1, req_error[5]=1, timeout_flag=0.
- Timeout: TIMEOUT=100, master never raises ready → m_abort pulse at counter 99, req_done and req_error=1, timeout_flag stays 1 until reset.
- No-busy: master never drops ready after m_start, BUSY_WAIT=16 → req_done and req_error after 16 cycles; no m_abort.
- Async reset mid WAIT_DONE: reset=0 asserted between clock edges → grant=0, m_start=0 immediately. After release with req_start=8'h80, requester 0's earlier request is not remembered and arbitration restarts at rr_ptr=0 → grant 8'h80.
